// File: rtl/axi_defs_pkg.sv
// axi_defs: shared AXI burst/response/size encodings, FSM state type and WRAP length check
package axi_defs;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [2:0] SIZE_4B = 3'b010;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_RESP} state_t;
  function automatic logic bad_wrap(input logic [1:0] burst, input logic [7:0] len);
    return burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
  endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next beat address for FIXED, INCR and WRAP bursts (WRAP len already validated)
module axi_burst_addr import axi_defs::*; #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next
);
  logic [ADDR_W-1:0] inc, mask;
  assign inc = addr + ADDR_W'(4);
  assign mask = ADDR_W'({len, 2'b11});
  assign next = burst == BURST_FIXED ? addr :
                burst == BURST_WRAP ? (addr & ~mask) | (inc & mask) : inc;
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder over an internal word RAM; define AXI_RAND_STALL_EN for LFSR handshake stalls
module axi_sram_slave import axi_defs::*; #(
  parameter int ADDR_W = 32,
  parameter int ID_W = 4,
  parameter int DEPTH = 4096,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
  state_t state;
  logic prio_rd, err, dec, stall, rv_up, oob, pick_rd, ar_hs, aw_hs, r_hs, w_hs;
  logic [ID_W-1:0] id;
  logic [ADDR_W-1:0] addr, next;
  logic [7:0] len, cnt;
  logic [1:0] burst, resp;
  logic [3:0] wcnt;
  logic [31:0] mem [DEPTH];
  axi_burst_addr #(.ADDR_W(ADDR_W)) u_addr (.addr(addr), .len(len), .burst(burst), .next(next));
  assign oob = (addr >> 2) >= DEPTH_W;
  assign pick_rd = arvalid && (!awvalid || prio_rd);
  assign arready = rst && state == IDLE && pick_rd && !stall;
  assign awready = rst && state == IDLE && awvalid && !pick_rd && !stall;
  assign wready = state == WR_BEAT && !stall;
  assign rvalid = state == RD_BEAT && (rv_up || !stall);
  assign bvalid = state == WR_RESP;
  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs = rvalid && rready;
  assign w_hs = wvalid && wready;
  assign resp = oob ? RESP_DECERR : err ? RESP_SLVERR : RESP_OKAY;
  assign rdata = rvalid && !oob ? mem[addr[AW+1:2]] : '0;
  assign rresp = rvalid ? resp : RESP_OKAY;
  assign rlast = rvalid && cnt == '0;
  assign rid = id;
  assign bid = id;
  assign bresp = !bvalid ? RESP_OKAY : dec ? RESP_DECERR : err ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_RAND_STALL_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 chooses the stall cycles
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall = lfsr[1:0] == 2'b00;
  // once an R beat has been shown it stays valid until taken
  always_ff @(posedge clk or negedge rst)
    if (!rst) rv_up <= 1'b0;
    else rv_up <= rvalid && !rready;
`else
  assign stall = 1'b0;
  assign rv_up = 1'b0;
`endif
  // in-range write beats commit enabled bytes; RAM is never cleared
  always_ff @(posedge clk)
    if (w_hs && !oob)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
  // transaction FSM: arbitrate, latch the burst, walk beats, respond
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      prio_rd <= 1'b1;
      id <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      burst <= BURST_INCR;
      wcnt <= '0;
      err <= 1'b0;
      dec <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (ar_hs) begin
            id <= arid;
            addr <= araddr;
            len <= arlen;
            cnt <= arlen;
            burst <= bad_wrap(arburst, arlen) ? BURST_INCR : arburst;
            err <= arsize != SIZE_4B || bad_wrap(arburst, arlen);
            wcnt <= '0;
            prio_rd <= !prio_rd;
            state <= RD_LAT == 0 ? RD_BEAT : RD_WAIT;
          end else if (aw_hs) begin
            id <= awid;
            addr <= awaddr;
            len <= awlen;
            cnt <= awlen;
            burst <= bad_wrap(awburst, awlen) ? BURST_INCR : awburst;
            err <= awsize != SIZE_4B || bad_wrap(awburst, awlen);
            dec <= 1'b0;
            prio_rd <= !prio_rd;
            state <= WR_BEAT;
          end
        RD_WAIT:
          if (wcnt == 4'(RD_LAT - 1)) state <= RD_BEAT;
          else wcnt <= wcnt + 4'd1;
        RD_BEAT:
          if (r_hs) begin
            addr <= next;
            cnt <= cnt - 8'd1;
            if (cnt == '0) state <= IDLE;
          end
        WR_BEAT:
          if (w_hs) begin
            addr <= next;
            cnt <= cnt - 8'd1;
            err <= err || (wlast != (cnt == '0));
            dec <= dec || oob;
            if (cnt == '0) state <= WR_RESP;
          end
        WR_RESP:
          if (bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed plus randomized AXI bursts checked against an address/byte-level memory model
module tb_axi_sram_slave;
  localparam int DEPTH = 4096;
  localparam int RD_LAT = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] arid = '0, awid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, rdata, wdata = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic [2:0] arsize = 3'b010, awsize = 3'b010;
  logic [1:0] arburst = 2'b01, awburst = 2'b01, rresp, bresp;
  logic arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
  logic awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic [3:0] wstrb = 4'hF;
  int tests = 0, fails = 0;
  bit prio_rd = 1'b1;
  logic [31:0] mm [int];
  logic [31:0] wd [16];
  logic [3:0] ws [16];

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(32), .ID_W(4), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wrap_ok(input int len);
    return len == 1 || len == 3 || len == 7 || len == 15;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input logic [1:0] bt, input int i);
    logic [31:0] sz, base;
    if (bt == 2'b00) return a;
    if (bt == 2'b10 && wrap_ok(len)) begin
      sz = 32'((len + 1) * 4);
      base = a - a % sz;
      return base + (a - base + 32'(4 * i)) % sz;
    end
    return a + 32'(4 * i);
  endfunction

  function automatic logic [1:0] burst_resp(input logic [2:0] sz, input logic [1:0] bt, input int len);
    return (sz != 3'b010 || (bt == 2'b10 && !wrap_ok(len))) ? 2'b10 : 2'b00;
  endfunction

  task automatic arb_check(input string tag);
    @(negedge clk);
    arvalid = 1'b1;
    awvalid = 1'b1;
    #1;
    chk({tag, "_arready"}, arready, prio_rd);
    chk({tag, "_awready"}, awready, !prio_rd);
    arvalid = 1'b0;
    awvalid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] bt,
                    input logic [2:0] sz, input int last_at);
    int n, k;
    logic [31:0] ba;
    bit dec, err;
    err = burst_resp(sz, bt, len) != 2'b00 || last_at != len;
    dec = 1'b0;
    @(negedge clk);
    awid = id; awaddr = a; awlen = 8'(len); awsize = sz; awburst = bt; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    prio_rd = ~prio_rd;
    for (int i = 0; i <= len; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at); wvalid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk("w_ready", wready, 1);
      ba = beat_addr(a, len, bt, i);
      if (ba / 4 < DEPTH) begin
        k = int'(ba / 4);
        if (!mm.exists(k)) mm[k] = 'x;
        for (int b = 0; b < 4; b++) if (ws[i][b]) mm[k][8*b +: 8] = wd[i][8*b +: 8];
      end else dec = 1'b1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, dec ? 2'b11 : err ? 2'b10 : 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_done", bvalid, 0);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] bt,
                    input logic [2:0] sz, input int mode);
    int n, lat;
    bit st;
    logic [31:0] ba, ed;
    logic [1:0] er;
    @(negedge clk);
    arid = id; araddr = a; arlen = 8'(len); arsize = sz; arburst = bt; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_accept", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    prio_rd = ~prio_rd;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid && lat < 50);
    chk("rd_latency", lat, RD_LAT + 1);
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      ba = beat_addr(a, len, bt, i);
      ed = ba / 4 < DEPTH ? mm[int'(ba / 4)] : 32'h0;
      er = ba / 4 < DEPTH ? burst_resp(sz, bt, len) : 2'b11;
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, ed);
      chk("rresp", rresp, er);
      chk("rlast", rlast, i == len);
      chk("rid", rid, id);
      st = mode == 1 ? (i % 2 == 1) : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (st) begin
        rready = 1'b0;
        @(negedge clk);
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, ed);
        chk("r_hold_last", rlast, i == len);
      end
      rready = 1'b1;
      @(negedge clk);
    end
    rready = 1'b0;
    chk("r_done", rvalid, 0);
  endtask

  initial begin
    int n, len;
    logic [1:0] bt;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_resp", {rresp, bresp}, 0);
    chk("rst_ids", {rid, bid}, 0);
    @(negedge clk) rst = 1'b1;

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr(4'd1, 32'h100, 0, 2'b01, 3'b010, 0);
    rd(4'd2, 32'h100, 0, 2'b01, 3'b010, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    wr(4'd3, 32'h200, 3, 2'b01, 3'b010, 3);
    rd(4'd4, 32'h200, 3, 2'b01, 3'b010, 1);
    rd(4'd5, 32'h208, 3, 2'b10, 3'b010, 0);

    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    wr(4'd6, 32'h300, 0, 2'b01, 3'b010, 0);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    wr(4'd7, 32'h300, 0, 2'b01, 3'b010, 0);
    rd(4'd8, 32'h300, 0, 2'b01, 3'b010, 0);

    arb_check("arb1");
    rd(4'd9, 32'h100, 0, 2'b01, 3'b010, 0);
    arb_check("arb2");
    wd[0] = 32'hCAFE0001; ws[0] = 4'hF;
    wr(4'd10, 32'h304, 0, 2'b01, 3'b010, 0);
    rd(4'd11, 32'h304, 0, 2'b01, 3'b010, 0);
    arb_check("arb3");

    wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A; ws[0] = 4'hF; ws[1] = 4'hF;
    wr(4'd12, 32'h400, 1, 2'b01, 3'b010, 0);
    wr(4'd13, 32'h408, 1, 2'b01, 3'b010, 99);
    wd[0] = 32'h0BADF00D;
    wr(4'd14, 32'h0, 0, 2'b01, 3'b010, 0);
    wd[0] = 32'h77777777;
    wr(4'd15, 32'(DEPTH * 4), 0, 2'b01, 3'b010, 0);
    rd(4'd1, 32'h0, 0, 2'b01, 3'b010, 0);
    rd(4'd2, 32'(DEPTH * 4), 0, 2'b01, 3'b010, 0);
    rd(4'd3, 32'h100, 0, 2'b01, 3'b000, 0);
    rd(4'd4, 32'h200, 2, 2'b10, 3'b010, 0);
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    wr(4'd5, 32'h500, 2, 2'b00, 3'b010, 2);
    rd(4'd6, 32'h500, 2, 2'b00, 3'b010, 1);

    @(negedge clk);
    arid = 4'd9; araddr = 32'h200; arlen = 8'd3; arburst = 2'b01; arsize = 3'b010; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("mid_ar_accept", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("mid_pre_rvalid", rvalid, 1);
    rready = 1'b1;
    @(negedge clk);
    chk("mid_beat2_data", rdata, 32'h2);
    rst = 1'b0;
    #1;
    chk("mid_rst_rvalid_async", rvalid, 0);
    @(posedge clk); #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rlast", rlast, 0);
    rready = 1'b0;
    prio_rd = 1'b1;
    @(negedge clk) rst = 1'b1;
    arb_check("arb_after_rst");
    rd(4'd10, 32'h204, 0, 2'b01, 3'b010, 0);

    for (int t = 0; t < 25; t++) begin
      bt = 2'($urandom_range(0, 2));
      len = bt == 2'b10 ? (1 << $urandom_range(1, 4)) - 1 : int'($urandom_range(0, 7));
      a = 32'($urandom_range(256, 3800)) * 4;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr(4'($urandom_range(0, 15)), a, len, bt, 3'b010, len);
      rd(4'($urandom_range(0, 15)), a, len, bt, 3'b010, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder (slave) backed by an internal word-addressed RAM.
- Answers read and write bursts from the CPU-side AXI master, so its ready/valid timing drives inst_stall_F and data_stall_M in the pipeline.
- Used as the on-chip memory model for core bring-up and cache-miss refill verification.
- Serves one transaction at a time, with fair read/write arbitration.

Parameters:
- ADDR_W, 32, AXI address width.
- ID_W, 4, width of the AXI ID fields.
- DEPTH, 4096, RAM size in 32-bit words; must be a power of two.
- RD_LAT, 2, wait cycles between AR acceptance and the first R beat (0..15).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 resets.
- arid  in  ID_W  read ID.
- araddr  in  ADDR_W  read start address.
- arlen  in  8  beats minus 1.
- arsize  in  3  beat size; must be 3'b010.
- arburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
- arvalid  in  1  read address valid.
- arready  out  1  read address accept.
- rid  out  ID_W  echoed arid.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rlast  out  1  final beat of the read burst.
- rvalid  out  1  read data valid.
- rready  in  1  master accepts the R beat.
- awid, awaddr, awlen, awsize, awburst, awvalid  in  ID_W/ADDR_W/8/3/2/1  write address channel.
- awready  out  1  write address accept.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  final write beat.
- wvalid  in  1  write data valid.
- wready  out  1  write data accept.
- bid  out  ID_W  echoed awid.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  master accepts the B response.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, priority flag favours read. RAM contents are not cleared.
- Reset asserted mid-burst: the burst is abandoned immediately with no response. RAM writes already committed remain.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_RESP.
- IDLE arbitration:
  - arvalid only: serve read.
  - awvalid only: serve write.
  - Both: serve the channel not served last; the last-served flag toggles on every accept.
  - arready/awready are driven high combinationally in IDLE for the chosen channel only.
  - The handshake latches id, addr, len and burst, loads the beat counter with len, and moves to RD_WAIT or WR_BEAT.
- RD_WAIT: counts RD_LAT cycles, then goes to RD_BEAT. When RD_LAT=0, the first R beat is valid the cycle after AR acceptance.
- RD_BEAT:
  - rvalid=1; rdata = RAM[index]; rid latched.
  - rlast = (counter==0).
  - rvalid/rdata/rlast hold stable until rready.
  - On a handshake, the address advances and the counter decrements. After the rlast handshake, return to IDLE.
  - Beats are back-to-back (one per cycle) while rready stays high.
- WR_BEAT:
  - wready=1.
  - Each handshake writes the bytes enabled by wstrb to RAM[index] and advances the address.
  - The burst terminates when len+1 beats are accepted, regardless of wlast.
  - wlast missing on the final beat, or present early, sets a sticky error so bresp=SLVERR (2'b10). Data is still written.
- WR_RESP: bvalid=1 held until bready, then IDLE.
- Address rules:
  - index = addr[ADDR_W-1:2].
  - Addresses beyond DEPTH words return DECERR (2'b11) with rdata=0; writes there are dropped.
  - INCR: +4 per beat, with 4 KB crossing allowed internally.
  - FIXED: address constant.
  - WRAP: wraps at a (len+1)*4-byte aligned boundary; len must be 1, 3, 7 or 15, otherwise the response is SLVERR and the burst is treated as INCR.
- arsize/awsize other than 3'b010: response SLVERR, beats still completed.
- rresp for a burst is per-beat; OKAY=2'b00.
- Simultaneous AR and AW in the same cycle as a burst completes: the handshake is not taken until the FSM is back in IDLE (minimum one idle cycle between transactions).

Optional Feature:
- Macro: AXI_RAND_STALL_EN.
- When defined, a 16-bit LFSR (seed 16'hACE1 at reset) gates arready, awready, wready and rvalid. Each is masked in a cycle where lfsr[1:0]==2'b00, stressing the pipeline's stall paths. The AXI rule that a raised rvalid is never withdrawn still holds: masking applies only before rvalid first rises for a beat.
- When undefined: no LFSR logic, and timing is exactly as above.

Decomposition:
- Shared package axi_defs: BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, SIZE_4B, and the FSM state typedef.
- One sub-module, axi_burst_addr: next-address computation for FIXED/INCR/WRAP, including WRAP boundary masking. It is combinational and reused for both channels.

Test Plan:
- Single write awaddr=0x100, wdata=0xDEADBEEF, wstrb=4'hF, then read arlen=0 → rdata=0xDEADBEEF, rresp=00, rlast=1, first rvalid 3 cycles after AR handshake (RD_LAT=2).
- INCR write of 4 beats from 0x200 (data 1..4), then INCR read of 4 beats with rready toggling 1,0,1,0 → data 1,2,3,4 held stable across stalls, rlast only on beat 4.
- WRAP read arlen=3 from 0x208 → beats from 0x208, 0x20C, 0x200, 0x204.
- Partial write wstrb=4'b0101, wdata=0x11223344 over 0xFFFFFFFF → readback 0xFF22FF44.
- arvalid and awvalid asserted together twice → read served first, then write; the next simultaneous pair serves write first.
- Error cases: write arlen/awlen=1 with wlast on beat 0 → bresp=10. Read at word index DEPTH → rresp=11, rdata=0. rst pulled low mid read burst → rvalid=0 next edge, IDLE.
